main_mem_arb: RTL
=================

# main_mem_arb

Parametrised shared-memory and mutex arbiter for the multi-core build. It sits between C core channels and one single-port synchronous data memory. Per cycle it grants at most one memory access, writes before reads, with round-robin fairness inside each class, and returns read data tagged to the granted channel. It also owns a LOCKS-entry mutex table with per-lock owner tracking and round-robin lock/unlock arbitration.

## Interface
- C, 8, number of core channels (≥2)
- AW, 16, memory address width
- DW, 16, memory data width
- LOCKS, 1024, mutex entries; LW = $clog2(LOCKS)
- clk  in  1  clock
- reset_n  in  1  reset, synchronous, active-low
- req_valid  in  C  per-channel memory request
- req_write  in  C  1 = write, 0 = read
- req_adr  in  C×AW  request address
- req_wdat  in  C×DW  write data
- req_ready  out  C  one-hot or zero grant; transfer when valid&ready
- mem_en  out  1  memory access this cycle
- mem_we  out  1  memory write strobe
- mem_adr  out  AW  memory address
- mem_wdat  out  DW  memory write data
- mem_rdat  in  DW  memory read data, valid 1 cycle after read access
- rsp_valid  out  C  one-hot read-response strobe
- rsp_dat  out  DW  read data
- lock_req  in  C  lock request
- unlock_req  in  C  unlock request
- lock_adr  in  C×LW  mutex index per channel
- lock_ac  out  C  one-hot or zero lock/unlock acknowledge

## Operation
- Memory class select: if any valid&write, candidates = writers; else candidates = valid readers.
- Round-robin among candidates starting at mem_ptr; granted index g. After grant, mem_ptr ← (g+1) mod C. No grant: pointer holds.
- mem_en = any grant; mem_we = req_write[g]; mem_adr/mem_wdat from channel g; all zero when no grant.
- Read grant: rsp_valid[g]=1 and rsp_dat=mem_rdat exactly one cycle later. Write grant: no response.
- Requester holds valid/write/adr/wdat stable until ready.
- Lock class select: if any unlock_req, candidates = unlockers; else candidates = lockers whose mutex[lock_adr] is 0.
- Round-robin among candidates from lock_ptr; winner u; lock_ac[u]=1; lock_ptr ← (u+1) mod C.
- Lock grant: mutex[adr] ← 1, owner[adr] ← u at next edge.
- Unlock grant: always acknowledged; clears mutex[adr] subject to Configuration.
- Lock on held entry (including by current owner): no ack, requester keeps requesting; non-reentrant.
- Lock and unlock of the same entry in one cycle: unlock wins; the lock is acked the next cycle if still requested.
- One lock-table update per cycle, independent of memory arbitration.
- Reset (reset_n=0 at an edge): mem_ptr=0, lock_ptr=0, rsp_valid=0, rsp_dat=0, all mutex=0, all owner=0. While reset_n=0: req_ready=0, lock_ac=0, mem_en=0, mem_we=0. A read accepted the cycle before reset produces no response.

## Timing
- req_ready, mem_* and lock_ac are combinational from inputs and registered state; same-cycle grant.
- Read latency: accept at edge N → rsp_valid at cycle N+1.
- Throughput: one memory access per cycle; one lock op per cycle.
- Mutex state changes are visible in the cycle after the ack.
- Starvation bound: any held request is granted within C grants of its class. Reads can starve only under continuous writes (accepted).

## Configuration
- LOCK_OWNER_CHECK_EN defined: unlock clears mutex only if mutex=1 and owner==requester; otherwise ack with no state change.
- Undefined: any acknowledged unlock clears mutex[adr]; owner table still written but unused.

## Structure
- Package main_mem_pkg: default C/AW/DW/LOCKS constants, LW derivation, and the channel-index typedef ($clog2(C) bits).
- Sub-module rr_arbiter #(N): request vector and pointer in, one-hot grant and next pointer out. Instantiated once for memory and once for locks.
- Mutex and owner arrays are flat registers in main_mem_arb.

## Test plan
- All 8 channels read continuously from reset → grants 0,1,…,7,0 in consecutive cycles; each rsp_valid one cycle after its grant.
- ch2 writes 0x0010=0xBEEF while ch5 reads 0x0010 → ch2 granted cycle 0, ch5 granted cycle 1, rsp_valid[5] at cycle 2 with rsp_dat=0xBEEF.
- ch1 and ch3 lock entry 7 with lock_ptr=0 → lock_ac[1]; ch3 stalls. ch1 unlocks 7 → lock_ac[1]. Next cycle → lock_ac[3].
- ch1 holds 7; ch4 unlocks 7; ch6 then locks 7 → with LOCK_OWNER_CHECK_EN: lock_ac[4], ch6 never acked. Without it: lock_ac[4], then lock_ac[6].
- ch0 unlocks 7 while ch2 locks 7 in the same cycle (7 held) → lock_ac[0] only; lock_ac[2] the next cycle.
- Read accepted, then reset_n=0 for 1 cycle → no rsp_valid. After reset, a lock on any entry is acked immediately; grant order restarts at ch0.

Source files
------------

// File: rtl/main_mem_pkg.sv
// Shared defaults and types for the multi-core memory / mutex arbiter.
package main_mem_pkg;

  localparam int unsigned C_DEFAULT     = 8;
  localparam int unsigned AW_DEFAULT    = 16;
  localparam int unsigned DW_DEFAULT    = 16;
  localparam int unsigned LOCKS_DEFAULT = 1024;
  localparam int unsigned LW_DEFAULT    = $clog2(LOCKS_DEFAULT);
  localparam int unsigned CW_DEFAULT    = $clog2(C_DEFAULT);

  typedef logic [CW_DEFAULT-1:0] ch_idx_t;

endpackage

// File: rtl/main_mem_arb_if.sv
// Core-channel, memory-port and mutex signals of main_mem_arb, bundled for port hookup.
interface main_mem_arb_if
  import main_mem_pkg::*;
#(
  parameter int unsigned C     = C_DEFAULT,
  parameter int unsigned AW    = AW_DEFAULT,
  parameter int unsigned DW    = DW_DEFAULT,
  parameter int unsigned LOCKS = LOCKS_DEFAULT
);
  localparam int unsigned LW = $clog2(LOCKS);

  logic [C-1:0]           req_valid;
  logic [C-1:0]           req_write;
  logic [C-1:0][AW-1:0]   req_adr;
  logic [C-1:0][DW-1:0]   req_wdat;
  logic [C-1:0]           req_ready;
  logic                   mem_en;
  logic                   mem_we;
  logic [AW-1:0]          mem_adr;
  logic [DW-1:0]          mem_wdat;
  logic [DW-1:0]          mem_rdat;
  logic [C-1:0]           rsp_valid;
  logic [DW-1:0]          rsp_dat;
  logic [C-1:0]           lock_req;
  logic [C-1:0]           unlock_req;
  logic [C-1:0][LW-1:0]   lock_adr;
  logic [C-1:0]           lock_ac;

  // Arbiter side
  modport slave (
    input  req_valid, req_write, req_adr, req_wdat, mem_rdat,
    input  lock_req, unlock_req, lock_adr,
    output req_ready, mem_en, mem_we, mem_adr, mem_wdat,
    output rsp_valid, rsp_dat, lock_ac
  );

  // Cores plus memory side
  modport master (
    output req_valid, req_write, req_adr, req_wdat, mem_rdat,
    output lock_req, unlock_req, lock_adr,
    input  req_ready, mem_en, mem_we, mem_adr, mem_wdat,
    input  rsp_valid, rsp_dat, lock_ac
  );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first requester at or after ptr wins; pointer moves past the winner.
module rr_arbiter #(
  parameter int unsigned N  = 8,
  localparam int unsigned PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] gnt_idx,
  output logic          any,
  output logic [PW-1:0] next_ptr
);

  logic [PW:0] pos;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    pos     = '0;
    for (int unsigned i = 0; i < N; i++) begin
      pos = {1'b0, ptr} + (PW+1)'(i);
      if (pos >= (PW+1)'(N)) pos = pos - (PW+1)'(N);
      if (!any && req[pos[PW-1:0]]) begin
        any                 = 1'b1;
        gnt[pos[PW-1:0]]    = 1'b1;
        gnt_idx             = pos[PW-1:0];
      end
    end
  end

  assign next_ptr = !any ? ptr :
                    (gnt_idx == PW'(N - 1)) ? '0 : gnt_idx + PW'(1);

endmodule

// File: rtl/main_mem_arb.sv
// Shared single-port memory arbiter (writes first, round-robin) plus mutex table.
// Define LOCK_OWNER_CHECK_EN to let only the current owner release a held mutex.
module main_mem_arb
  import main_mem_pkg::*;
#(
  parameter int unsigned C     = C_DEFAULT,
  parameter int unsigned AW    = AW_DEFAULT,
  parameter int unsigned DW    = DW_DEFAULT,
  parameter int unsigned LOCKS = LOCKS_DEFAULT
) (
  input logic           clk,
  input logic           reset_n,
  main_mem_arb_if.slave bus
);

  localparam int unsigned LW = $clog2(LOCKS);
  localparam int unsigned CW = $clog2(C);

  logic [C-1:0]  run;
  logic [C-1:0]  wr_req, rd_req, mem_cand, mem_gnt, rsp_pend, rsp_valid_c;
  logic [CW-1:0] mem_ptr, mem_ptr_nxt, mem_gidx;
  logic          mem_any, mem_we_c;
  logic [AW-1:0] mem_adr_c;
  logic [DW-1:0] mem_wdat_c;

  logic [C-1:0]  unl_req, lk_free, lk_cand, lk_gnt;
  logic [CW-1:0] lock_ptr, lock_ptr_nxt, lk_gidx;
  logic          lk_any, lk_is_unl;
  logic [LW-1:0] lk_adr;

  logic [LOCKS-1:0]         mutex;
  logic [LOCKS-1:0][CW-1:0] owner;

  // Nothing is granted while reset is held
  assign run = {C{reset_n}};

  // Memory class select: any writer shuts out all readers this cycle
  assign wr_req   = bus.req_valid &  bus.req_write & run;
  assign rd_req   = bus.req_valid & ~bus.req_write & run;
  assign mem_cand = (|wr_req) ? wr_req : rd_req;

  rr_arbiter #(.N(C)) u_mem_rr (
    .req      (mem_cand),
    .ptr      (mem_ptr),
    .gnt      (mem_gnt),
    .gnt_idx  (mem_gidx),
    .any      (mem_any),
    .next_ptr (mem_ptr_nxt)
  );

  assign mem_we_c   = mem_any & bus.req_write[mem_gidx];
  assign mem_adr_c  = mem_any ? bus.req_adr[mem_gidx]  : '0;
  assign mem_wdat_c = mem_any ? bus.req_wdat[mem_gidx] : '0;

  assign bus.req_ready = mem_gnt;
  assign bus.mem_en    = mem_any;
  assign bus.mem_we    = mem_we_c;
  assign bus.mem_adr   = mem_adr_c;
  assign bus.mem_wdat  = mem_wdat_c;

  // Response pairs with the memory's next-cycle read data; reset squashes it
  assign rsp_valid_c   = rsp_pend & run;
  assign bus.rsp_valid = rsp_valid_c;
  assign bus.rsp_dat   = (|rsp_valid_c) ? bus.mem_rdat : '0;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mem_ptr  <= '0;
      rsp_pend <= '0;
    end else begin
      mem_ptr  <= mem_ptr_nxt;
      rsp_pend <= (mem_any && !mem_we_c) ? mem_gnt : '0;
    end
  end

  // Lock class select: unlocks pre-empt locks; locks only compete for free entries
  for (genvar c = 0; c < C; c++) begin : g_free
    assign lk_free[c] = bus.lock_req[c] & ~mutex[bus.lock_adr[c]];
  end

  assign unl_req   = bus.unlock_req & run;
  assign lk_is_unl = |unl_req;
  assign lk_cand   = lk_is_unl ? unl_req : (lk_free & run);

  rr_arbiter #(.N(C)) u_lock_rr (
    .req      (lk_cand),
    .ptr      (lock_ptr),
    .gnt      (lk_gnt),
    .gnt_idx  (lk_gidx),
    .any      (lk_any),
    .next_ptr (lock_ptr_nxt)
  );

  assign lk_adr      = bus.lock_adr[lk_gidx];
  assign bus.lock_ac = lk_gnt;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      lock_ptr <= '0;
    end else begin
      lock_ptr <= lock_ptr_nxt;
    end
  end

  // Single mutex-table update per cycle
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mutex <= '0;
      owner <= '0;
    end else if (lk_any) begin
      if (lk_is_unl) begin
`ifdef LOCK_OWNER_CHECK_EN
        if (mutex[lk_adr] && (owner[lk_adr] == lk_gidx)) mutex[lk_adr] <= 1'b0;
`else
        mutex[lk_adr] <= 1'b0;
`endif
      end else begin
        mutex[lk_adr] <= 1'b1;
        owner[lk_adr] <= lk_gidx;
      end
    end
  end

`ifndef LOCK_OWNER_CHECK_EN
  logic unused_owner;
  assign unused_owner = ^owner;
`endif

endmodule
